keypad_code_entry: RTL and testbench
====================================

# keypad_code_entry

Parametrised keypad code-entry engine that sits between the keypad scanner and the code checker. It collects `DIGITS` key codes into a shift register and supports clear, backspace and a configurable full-buffer mode. It enforces a post-key hold-off and an inactivity timeout. On the enter key it publishes the collected code with a one-cycle valid strobe.

## Interface
Parameters:
- `DIGITS`, 4: maximum digits held.
- `KEY_W`, 4: key code width.
- `HOLD_CYCLES`, 64: hold-off cycles after each processed key (≥1).
- `TIMEOUT_CYCLES`, 3750: idle cycles in WAIT before the entry is abandoned (≥1).
- `FULL_MODE`, 0: 0 = a digit into a full buffer shifts out the oldest digit; 1 = the digit is rejected.
- `KEY_ENTER`, 'hF; `KEY_CLEAR`, 'hE; `KEY_BACK`, 'hD: control key codes, which are never stored as digits.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_pressed` in 1: key event qualifier, level.
- `key` in KEY_W: key code, valid while `key_pressed`.
- `entry_out` out DIGITS*KEY_W: live buffer; newest digit in the LSBs.
- `code_out` out DIGITS*KEY_W: last submitted code; held until the next submit.
- `code_valid` out 1: one-cycle strobe when `code_out` updates.
- `digit_count` out $clog2(DIGITS+1): digits currently held.
- `timeout` out 1: one-cycle strobe when an entry is abandoned.
- `busy` out 1: high in any state other than IDLE.

## Operation
States are IDLE, CAPTURE, HOLD and WAIT.
- **IDLE:** `entry_out` is 0 and `digit_count` is 0. `key_pressed`=1 registers `key` into `key_q` and moves to CAPTURE.
- **CAPTURE** (one cycle) processes `key_q`, then goes to HOLD.
  - **ENTER, `digit_count`>0:** `code_out`←`entry_out`; `code_valid`=1 for one cycle; entry and count cleared.
  - **ENTER, `digit_count`=0:** no effect, no strobe.
  - **CLEAR:** entry and count cleared.
  - **BACK:** `entry_out`←`entry_out`>>KEY_W; count decremented. At count 0 there is no effect.
  - **Digit, count<DIGITS:** `entry_out`←{`entry_out`[hi-KEY_W:0], `key_q`}; count+1.
  - **Digit, count=DIGITS:** with FULL_MODE=0, shift in and drop the oldest digit (count stays DIGITS). With FULL_MODE=1, no change.
- **HOLD:** `key_pressed` is ignored. After `HOLD_CYCLES` cycles, go to WAIT if count>0, else IDLE.
- **WAIT:** `key_pressed`=1 registers `key` and goes to CAPTURE; the timeout counter is cleared. If `TIMEOUT_CYCLES` consecutive cycles pass with no press, `timeout`=1 for one cycle, the entry and count are cleared, and the state returns to IDLE. `code_out` is untouched by a timeout.
- **Held key:** a key still held when HOLD ends is captured again. This auto-repeat at period HOLD_CYCLES+2 is intended.

## Timing
- **Reset:** all outputs are 0, the state is IDLE and the counters are 0. Assertion takes effect immediately, including mid-entry or mid-HOLD. After release, the first active edge behaves as IDLE.
- **Latency:** a press sampled at edge t puts the state in CAPTURE after t. `entry_out`, `digit_count`, `code_out` and `code_valid` update at edge t+1.
- **HOLD:** occupies cycles t+2 … t+1+HOLD_CYCLES. The next press can be sampled at the first WAIT/IDLE cycle.
- **Strobes:** `code_valid` and `timeout` are registered outputs. They are never high in the same cycle.
- **Counter:** its width is $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1). It is reloaded on every state entry and never wraps.

## Structure
- **Package `keypad_pkg`:** state enum, default control key codes, and a `clog2`-based count-width helper.
- **Sub-module `keypad_timer`:** loadable down-counter with a terminal-count pulse. One instance is shared by HOLD and WAIT, which are mutually exclusive.

## Test plan
Configuration: DIGITS=4, HOLD_CYCLES=4, TIMEOUT_CYCLES=20 unless noted.
1. **Submit:** keys 1,2,3,4,F → `code_out`=16'h1234; `code_valid` high exactly 1 cycle; `entry_out`=0; `digit_count`=0; IDLE.
2. **Full buffer:** keys 1,2,3,4,5,F. With FULL_MODE=0 → `code_out`=16'h2345. With FULL_MODE=1 → 16'h1234.
3. **Backspace and clear:**
   - Keys 1,2,D,3,F → 16'h0013.
   - Keys 1,2,E,7,F → 16'h0007.
   - Lone F from IDLE → no `code_valid`.
4. **Timeout:** key 9, then no press → `timeout` pulse 20 cycles after WAIT entry; `entry_out`=0; IDLE; `code_out` keeps its prior value.
5. **Hold-off:** a 1-cycle press of key 5 during HOLD → ignored; `entry_out` unchanged.
6. **Reset:** `rst_n` low mid-entry (count=2) → all outputs 0 asynchronously. After release, keys 8,F → 16'h0008.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and helpers for the keypad code-entry engine.
//               Holds the controller state encoding, the default control key
//               codes and the width helper for the shared hold/idle timer.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Controller states: explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  // Default control key codes (resized to the key width at the top level).
  localparam int unsigned c_key_enter = 'hF;
  localparam int unsigned c_key_clear = 'hE;
  localparam int unsigned c_key_back  = 'hD;

  // Width of a down-counter that must be able to hold the larger of two
  // cycle counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_timer.sv
`default_nettype none
// ============================================================================
// Module      : keypad_timer
// Description : Loadable down-counter with a terminal-count indication.
//               A load always wins over counting. The counter stops at zero
//               and never wraps; done is high while enabled at zero.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               load, load_val   - reload request and reload value
//               en               - count enable
//               done             - enabled and count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign done = en && (r_count == '0);

endmodule : keypad_timer
`default_nettype wire

// File: rtl/keypad_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_code_entry
// Description : Keypad code-entry engine. Collects DIGITS key codes into a
//               shift register (newest digit in the LSBs), handles clear,
//               backspace and enter, enforces a hold-off after every key and
//               abandons an idle entry after TIMEOUT_CYCLES.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               key_pressed, key  - key event qualifier and key code
//               entry_out         - live digit buffer
//               code_out          - last submitted code
//               code_valid        - one-cycle strobe on code_out update
//               digit_count       - digits currently held
//               timeout           - one-cycle strobe on abandoned entry
//               busy              - controller is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int               DIGITS         = 4,
  parameter int               KEY_W          = 4,
  parameter int               HOLD_CYCLES    = 64,
  parameter int               TIMEOUT_CYCLES = 3750,
  parameter bit               FULL_MODE      = 1'b0,
  parameter logic [KEY_W-1:0] KEY_ENTER      = KEY_W'(c_key_enter),
  parameter logic [KEY_W-1:0] KEY_CLEAR      = KEY_W'(c_key_clear),
  parameter logic [KEY_W-1:0] KEY_BACK       = KEY_W'(c_key_back)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_pressed,
  input  logic [KEY_W-1:0]             key,
  output logic [DIGITS*KEY_W-1:0]      entry_out,
  output logic [DIGITS*KEY_W-1:0]      code_out,
  output logic                         code_valid,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         timeout,
  output logic                         busy
);

  localparam int c_entry_w = DIGITS * KEY_W;
  localparam int c_dcnt_w  = $clog2(DIGITS + 1);
  localparam int c_tmr_w   = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);

  // The timer counts down to zero inclusive, so N cycles load N-1.
  localparam logic [c_tmr_w-1:0] c_hold_load = c_tmr_w'(HOLD_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_wait_load = c_tmr_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_dcnt_w-1:0] c_full_cnt = c_dcnt_w'(DIGITS);

  state_t                r_state, w_state_next;
  logic [KEY_W-1:0]      r_key_q;
  logic [c_entry_w-1:0]  r_entry, w_entry_next;
  logic [c_entry_w-1:0]  r_code, w_code_next;
  logic [c_dcnt_w-1:0]   r_count, w_count_next;
  logic                  r_code_valid, w_code_valid_next;
  logic                  r_timeout, w_timeout_next;
  logic                  w_key_load;
  logic                  w_tmr_load;
  logic [c_tmr_w-1:0]    w_tmr_val;
  logic                  w_tmr_en;
  logic                  w_tmr_done;
  logic                  w_full_shift;
  logic [c_entry_w-1:0]  w_shifted;

  // Behaviour of a digit arriving at a full buffer.
  generate
    if (FULL_MODE) begin : g_full_reject
      assign w_full_shift = 1'b0;
    end else begin : g_full_shift
      assign w_full_shift = 1'b1;
    end
  endgenerate

  // Buffer with the captured key appended as the newest digit.
  assign w_shifted = (r_entry << KEY_W) | c_entry_w'(r_key_q);

  // HOLD and WAIT never overlap, so one timer serves both.
  assign w_tmr_en = (r_state == ST_HOLD) || (r_state == ST_WAIT);

  keypad_timer #(
    .WIDTH (c_tmr_w)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .en       (w_tmr_en),
    .done     (w_tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_key_q      <= '0;
      r_entry      <= '0;
      r_code       <= '0;
      r_count      <= '0;
      r_code_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_entry      <= w_entry_next;
      r_code       <= w_code_next;
      r_count      <= w_count_next;
      r_code_valid <= w_code_valid_next;
      r_timeout    <= w_timeout_next;
      if (w_key_load) begin
        r_key_q <= key;
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_entry_next      = r_entry;
    w_code_next       = r_code;
    w_count_next      = r_count;
    w_code_valid_next = 1'b0;
    w_timeout_next    = 1'b0;
    w_key_load        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (key_pressed) begin
          w_key_load   = 1'b1;
          w_state_next = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        w_state_next = ST_HOLD;
        if (r_key_q == KEY_ENTER) begin
          if (r_count != '0) begin
            w_code_next       = r_entry;
            w_code_valid_next = 1'b1;
            w_entry_next      = '0;
            w_count_next      = '0;
          end
        end else if (r_key_q == KEY_CLEAR) begin
          w_entry_next = '0;
          w_count_next = '0;
        end else if (r_key_q == KEY_BACK) begin
          if (r_count != '0) begin
            w_entry_next = r_entry >> KEY_W;
            w_count_next = r_count - c_dcnt_w'(1);
          end
        end else if (r_count < c_full_cnt) begin
          w_entry_next = w_shifted;
          w_count_next = r_count + c_dcnt_w'(1);
        end else if (w_full_shift) begin
          // Oldest digit falls off the top; count stays at DIGITS.
          w_entry_next = w_shifted;
        end
      end

      ST_HOLD: begin
        if (w_tmr_done) begin
          w_state_next = (r_count != '0) ? ST_WAIT : ST_IDLE;
        end
      end

      ST_WAIT: begin
        // A press on the last idle cycle still counts as activity.
        if (key_pressed) begin
          w_key_load   = 1'b1;
          w_state_next = ST_CAPTURE;
        end else if (w_tmr_done) begin
          w_timeout_next = 1'b1;
          w_entry_next   = '0;
          w_count_next   = '0;
          w_state_next   = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Reload the timer on every state change with the budget of the new state.
  always_comb begin
    w_tmr_load = (w_state_next != r_state);
    w_tmr_val  = '0;
    if (w_state_next == ST_HOLD) begin
      w_tmr_val = c_hold_load;
    end else if (w_state_next == ST_WAIT) begin
      w_tmr_val = c_wait_load;
    end
  end

  assign entry_out   = r_entry;
  assign code_out    = r_code;
  assign code_valid  = r_code_valid;
  assign digit_count = r_count;
  assign timeout     = r_timeout;
  assign busy        = (r_state != ST_IDLE);

endmodule : keypad_code_entry
`default_nettype wire

// File: tb/tb_keypad_code_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_code_entry
// Description : Directed self-checking bench for keypad_code_entry with
//               DIGITS=4, HOLD_CYCLES=4, TIMEOUT_CYCLES=20. A second instance
//               with FULL_MODE=1 shares the stimulus for the reject case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_code_entry;

  logic        clk;
  logic        rst_n;
  logic        key_pressed;
  logic [3:0]  key;

  logic [15:0] entry_out, code_out;
  logic        code_valid, timeout, busy;
  logic [2:0]  digit_count;

  logic [15:0] entry_out_r, code_out_r;
  logic        code_valid_r, timeout_r, busy_r;
  logic [2:0]  digit_count_r;

  int n_checks;
  int n_fail;

  keypad_code_entry #(
    .DIGITS         (4),
    .KEY_W          (4),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (20),
    .FULL_MODE      (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_pressed (key_pressed),
    .key         (key),
    .entry_out   (entry_out),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .digit_count (digit_count),
    .timeout     (timeout),
    .busy        (busy)
  );

  keypad_code_entry #(
    .DIGITS         (4),
    .KEY_W          (4),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (20),
    .FULL_MODE      (1'b1)
  ) dut_rej (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_pressed (key_pressed),
    .key         (key),
    .entry_out   (entry_out_r),
    .code_out    (code_out_r),
    .code_valid  (code_valid_r),
    .digit_count (digit_count_r),
    .timeout     (timeout_r),
    .busy        (busy_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press; returns on the negedge after the sampling edge (CAPTURE).
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_pressed = 1'b1;
    key         = k;
    @(negedge clk);
    key_pressed = 1'b0;
  endtask

  // Press and wait until the last HOLD cycle; the next press lands in WAIT/IDLE.
  task automatic key_seq(input logic [3:0] k);
    press(k);
    tick(4);
  endtask

  // Enter key with a code expected; checks the strobe is exactly one cycle.
  task automatic submit(input string tag, input logic [15:0] exp);
    press(4'hF);
    check({tag, "_valid_pre"}, 32'(code_valid), 32'd0);
    tick(1);
    check({tag, "_valid"}, 32'(code_valid), 32'd1);
    check({tag, "_code"}, 32'(code_out), 32'(exp));
    check({tag, "_entry"}, 32'(entry_out), 32'd0);
    check({tag, "_count"}, 32'(digit_count), 32'd0);
    tick(1);
    check({tag, "_valid_post"}, 32'(code_valid), 32'd0);
    tick(3);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    key_pressed = 1'b0;
    key         = 4'h0;
    #1 rst_n = 1'b0;

    // Reset state
    tick(2);
    check("rst_entry", 32'(entry_out), 32'd0);
    check("rst_code", 32'(code_out), 32'd0);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Submit 1,2,3,4,F
    key_seq(4'h1);
    key_seq(4'h2);
    key_seq(4'h3);
    check("t1_entry3", 32'(entry_out), 32'h0123);
    check("t1_count3", 32'(digit_count), 32'd3);
    key_seq(4'h4);
    check("t1_entry4", 32'(entry_out), 32'h1234);
    check("t1_count4", 32'(digit_count), 32'd4);
    submit("t1", 16'h1234);

    // Full buffer: shifting instance vs rejecting instance
    key_seq(4'h1);
    key_seq(4'h2);
    key_seq(4'h3);
    key_seq(4'h4);
    key_seq(4'h5);
    check("t2_entry_shift", 32'(entry_out), 32'h2345);
    check("t2_count_shift", 32'(digit_count), 32'd4);
    check("t2_entry_rej", 32'(entry_out_r), 32'h1234);
    check("t2_count_rej", 32'(digit_count_r), 32'd4);
    submit("t2", 16'h2345);
    check("t2_code_rej", 32'(code_out_r), 32'h1234);

    // Backspace
    key_seq(4'h1);
    key_seq(4'h2);
    key_seq(4'hD);
    check("t3a_entry_back", 32'(entry_out), 32'h0001);
    check("t3a_count_back", 32'(digit_count), 32'd1);
    key_seq(4'h3);
    submit("t3a", 16'h0013);

    // Clear
    key_seq(4'h1);
    key_seq(4'h2);
    key_seq(4'hE);
    check("t3b_entry_clr", 32'(entry_out), 32'd0);
    check("t3b_count_clr", 32'(digit_count), 32'd0);
    key_seq(4'h7);
    submit("t3b", 16'h0007);

    // Lone enter from IDLE: no strobe, code kept
    press(4'hF);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t3c_no_valid", 32'(code_valid), 32'd0);
    end
    check("t3c_code_kept", 32'(code_out), 32'h0007);
    check("t3c_idle", 32'(busy), 32'd0);

    // Timeout: WAIT entered at the edge after this point, pulse 20 cycles later
    key_seq(4'h9);
    tick(20);
    check("t4_no_early_to", 32'(timeout), 32'd0);
    check("t4_entry_pre", 32'(entry_out), 32'h0009);
    check("t4_busy_pre", 32'(busy), 32'd1);
    tick(1);
    check("t4_timeout", 32'(timeout), 32'd1);
    check("t4_valid_low", 32'(code_valid), 32'd0);
    check("t4_entry", 32'(entry_out), 32'd0);
    check("t4_count", 32'(digit_count), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_code_kept", 32'(code_out), 32'h0007);
    tick(1);
    check("t4_timeout_post", 32'(timeout), 32'd0);

    // Hold-off: a press during HOLD is ignored
    press(4'h3);
    tick(1);
    key_pressed = 1'b1;
    key         = 4'h5;
    tick(1);
    key_pressed = 1'b0;
    tick(5);
    check("t5_entry", 32'(entry_out), 32'h0003);
    check("t5_count", 32'(digit_count), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    submit("t5", 16'h0003);

    // Asynchronous reset mid-entry
    key_seq(4'h1);
    key_seq(4'h2);
    check("t6_count_pre", 32'(digit_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_entry", 32'(entry_out), 32'd0);
    check("t6_code", 32'(code_out), 32'd0);
    check("t6_count", 32'(digit_count), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(code_valid), 32'd0);
    check("t6_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    key_seq(4'h8);
    submit("t6", 16'h0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_keypad_code_entry
`default_nettype wire
